// File: rtl/ex_dispatch_stage.sv
// ex_dispatch_stage: register-read / dispatch stage. Reads rs1/rs2 from the PRF,
// picks operand B and parks the uop in one of NUM_CH channels, each a
// two-entry main + skid buffer, so execution units backpressure without a
// combinational ready path back to issue.
// Ports:
//   cpu_clock_i, cpu_reset_i (async, active high), flush_i
//   data_i {rs2, rs1, rsvd, rob}, valid_i / ready_o  issue handshake
//   rob_o, rs1_o, rs2_o          combinational field slices of data_i
//   rs1_data_i, rs2_data_i, opcode_i, imm_i, immediate_i, dest_i, ch_i
//   ex_*_o, ex_valid_o / ex_ready_i  per-channel packets (channel c at slice c)
//   bad_ch_o                     one-cycle pulse when ch_i names no channel
module ex_dispatch_stage #(
    parameter int                NUM_CH   = 2,
    parameter int                XLEN     = 32,
    parameter int                ROB_W    = 5,
    parameter int                PRF_W    = 6,
    parameter int                OPC_W    = 7,
    parameter logic [NUM_CH-1:0] IMM_MASK = NUM_CH'(1),
    parameter int                CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                      cpu_clock_i,
    input  logic                      cpu_reset_i,
    input  logic                      flush_i,
    input  logic [ROB_W+2*PRF_W:0]    data_i,
    input  logic                      valid_i,
    output logic                      ready_o,
    output logic [ROB_W-1:0]          rob_o,
    output logic [PRF_W-1:0]          rs1_o,
    output logic [PRF_W-1:0]          rs2_o,
    input  logic [XLEN-1:0]           rs1_data_i,
    input  logic [XLEN-1:0]           rs2_data_i,
    input  logic [OPC_W-1:0]          opcode_i,
    input  logic                      imm_i,
    input  logic [XLEN-1:0]           immediate_i,
    input  logic [PRF_W-1:0]          dest_i,
    input  logic [CH_W-1:0]           ch_i,
    output logic [NUM_CH*XLEN-1:0]    ex_a_o,
    output logic [NUM_CH*XLEN-1:0]    ex_b_o,
    output logic [NUM_CH*OPC_W-1:0]   ex_opc_o,
    output logic [NUM_CH*ROB_W-1:0]   ex_rob_o,
    output logic [NUM_CH*PRF_W-1:0]   ex_dest_o,
    output logic [NUM_CH-1:0]         ex_valid_o,
    input  logic [NUM_CH-1:0]         ex_ready_i,
    output logic                      bad_ch_o
);

    typedef struct packed {
        logic [XLEN-1:0]  a;
        logic [XLEN-1:0]  b;
        logic [OPC_W-1:0] opc;
        logic [ROB_W-1:0] rob;
        logic [PRF_W-1:0] dest;
    } pkt_t;

    logic              ch_ok;
    logic              use_imm;
    logic              accept;
    logic [NUM_CH-1:0] skid_v;
    logic              unused_rsvd;
    pkt_t              new_pkt;

    assign rob_o       = data_i[ROB_W-1:0];
    assign unused_rsvd = data_i[ROB_W];
    assign rs1_o       = data_i[ROB_W+1 +: PRF_W];
    assign rs2_o       = data_i[ROB_W+1+PRF_W +: PRF_W];

    // An unmatched ch_i leaves ready_o high so the bad uop is consumed.
    always_comb begin
        ch_ok   = 1'b0;
        ready_o = 1'b1;
        use_imm = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (ch_i == CH_W'(c)) begin
                ch_ok   = 1'b1;
                ready_o = !skid_v[c];
                use_imm = imm_i & IMM_MASK[c];
            end
        end
    end

    assign accept = valid_i & ready_o & !flush_i & ch_ok;

    always_comb begin
        new_pkt      = '0;
        new_pkt.a    = rs1_data_i;
        new_pkt.b    = use_imm ? immediate_i : rs2_data_i;
        new_pkt.opc  = opcode_i;
        new_pkt.rob  = rob_o;
        new_pkt.dest = dest_i;
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic sel;
        logic drain;
        logic main_v_r;
        logic skid_v_r;
        pkt_t main_r;
        pkt_t skid_r;

        assign sel   = accept & (ch_i == CH_W'(c));
        assign drain = main_v_r & ex_ready_i[c];

        // A full skid forces ready_o low, so sel never coincides with
        // the skid-to-main move.
        always_ff @(posedge cpu_clock_i or posedge cpu_reset_i) begin
            if (cpu_reset_i) begin
                main_v_r <= 1'b0;
                skid_v_r <= 1'b0;
                main_r   <= '0;
                skid_r   <= '0;
            end else if (flush_i) begin
                main_v_r <= 1'b0;
                skid_v_r <= 1'b0;
            end else if (skid_v_r && drain) begin
                main_r   <= skid_r;
                skid_v_r <= 1'b0;
            end else if (sel && (!main_v_r || drain)) begin
                main_r   <= new_pkt;
                main_v_r <= 1'b1;
            end else if (sel) begin
                skid_r   <= new_pkt;
                skid_v_r <= 1'b1;
            end else if (drain) begin
                main_v_r <= 1'b0;
            end
        end

        assign skid_v[c]                   = skid_v_r;
        assign ex_valid_o[c]               = main_v_r;
        assign ex_a_o[c*XLEN +: XLEN]      = main_r.a;
        assign ex_b_o[c*XLEN +: XLEN]      = main_r.b;
        assign ex_opc_o[c*OPC_W +: OPC_W]  = main_r.opc;
        assign ex_rob_o[c*ROB_W +: ROB_W]  = main_r.rob;
        assign ex_dest_o[c*PRF_W +: PRF_W] = main_r.dest;
    end

    always_ff @(posedge cpu_clock_i or posedge cpu_reset_i) begin
        if (cpu_reset_i) begin
            bad_ch_o <= 1'b0;
        end else begin
            bad_ch_o <= valid_i & !flush_i & !ch_ok;
        end
    end

endmodule

// File: tb/tb_ex_dispatch_stage.sv
// tb_ex_dispatch_stage: table vectors, directed corner sequences and a
// random run against a two-deep FIFO-per-channel reference model.
module tb_ex_dispatch_stage;

    localparam int XLEN  = 32;
    localparam int ROB_W = 5;
    localparam int PRF_W = 6;
    localparam int OPC_W = 7;
    localparam int DW    = ROB_W + 1 + 2 * PRF_W;
    localparam int NV    = 15;

    typedef struct packed {
        logic [XLEN-1:0]  a;
        logic [XLEN-1:0]  b;
        logic [OPC_W-1:0] opc;
        logic [ROB_W-1:0] rob;
        logic [PRF_W-1:0] dest;
    } pkt_t;

    typedef struct packed {
        logic        v;
        logic [4:0]  rob;
        logic [5:0]  rs1;
        logic        im;
        logic [31:0] iv;
        logic        c;
        logic        fl;
        logic [1:0]  er;
        logic        rdy;
        logic [1:0]  ev;
        logic [31:0] a0;
        logic [31:0] b0;
        logic [4:0]  r0;
        logic [31:0] a1;
        logic [31:0] b1;
        logic [4:0]  r1;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic              flush, valid, imm, ready, bad;
    logic [DW-1:0]     data;
    logic [ROB_W-1:0]  rob_o;
    logic [PRF_W-1:0]  rs1_o, rs2_o, dest;
    logic [XLEN-1:0]   rs1_d, rs2_d, immv;
    logic [OPC_W-1:0]  opc;
    logic [0:0]        ch;
    logic [1:0]        exr, ev;
    logic [2*XLEN-1:0] ex_a, ex_b;
    logic [2*OPC_W-1:0] ex_opc;
    logic [2*ROB_W-1:0] ex_rob;
    logic [2*PRF_W-1:0] ex_dest;

    logic              valid1, ready1, bad1;
    logic [1:0]        ch1;
    logic [ROB_W-1:0]  rob1_o;
    logic [PRF_W-1:0]  rs1_1o, rs2_1o;
    logic [OPC_W-1:0]  opc1;
    logic [2:0]        ev1, exr1;
    logic [3*XLEN-1:0] ex_a1, ex_b1;
    logic [3*OPC_W-1:0] ex_opc1;
    logic [3*ROB_W-1:0] ex_rob1;
    logic [3*PRF_W-1:0] ex_dest1;

    logic [XLEN-1:0]  prf  [64];
    logic [OPC_W-1:0] iram [32];

    assign rs1_d = prf[rs1_o];
    assign rs2_d = prf[rs2_o];
    assign opc   = iram[rob_o];
    assign opc1  = iram[rob1_o];

    ex_dispatch_stage #(
        .NUM_CH(2), .XLEN(XLEN), .ROB_W(ROB_W), .PRF_W(PRF_W),
        .OPC_W(OPC_W), .IMM_MASK(2'b01)
    ) u_dut0 (
        .cpu_clock_i(clk), .cpu_reset_i(rst), .flush_i(flush),
        .data_i(data), .valid_i(valid), .ready_o(ready),
        .rob_o(rob_o), .rs1_o(rs1_o), .rs2_o(rs2_o),
        .rs1_data_i(rs1_d), .rs2_data_i(rs2_d), .opcode_i(opc),
        .imm_i(imm), .immediate_i(immv), .dest_i(dest), .ch_i(ch),
        .ex_a_o(ex_a), .ex_b_o(ex_b), .ex_opc_o(ex_opc),
        .ex_rob_o(ex_rob), .ex_dest_o(ex_dest),
        .ex_valid_o(ev), .ex_ready_i(exr), .bad_ch_o(bad)
    );

    ex_dispatch_stage #(
        .NUM_CH(3), .XLEN(XLEN), .ROB_W(ROB_W), .PRF_W(PRF_W),
        .OPC_W(OPC_W), .IMM_MASK(3'b001)
    ) u_dut1 (
        .cpu_clock_i(clk), .cpu_reset_i(rst), .flush_i(flush),
        .data_i(data), .valid_i(valid1), .ready_o(ready1),
        .rob_o(rob1_o), .rs1_o(rs1_1o), .rs2_o(rs2_1o),
        .rs1_data_i(rs1_d), .rs2_data_i(rs2_d), .opcode_i(opc1),
        .imm_i(imm), .immediate_i(immv), .dest_i(dest), .ch_i(ch1),
        .ex_a_o(ex_a1), .ex_b_o(ex_b1), .ex_opc_o(ex_opc1),
        .ex_rob_o(ex_rob1), .ex_dest_o(ex_dest1),
        .ex_valid_o(ev1), .ex_ready_i(exr1), .bad_ch_o(bad1)
    );

    int   n_vec  = 0;
    int   n_miss = 0;
    vec_t tv [NV];
    pkt_t mq [2][2];
    int   mn [2];
    logic [1:0] mask0 = 2'b01;

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] r,
                         input logic [5:0] s1, input logic [5:0] s2,
                         input logic rs, input logic im,
                         input logic [31:0] iv, input logic [5:0] d,
                         input logic c, input logic fl,
                         input logic [1:0] er);
        valid = v;
        data  = {s2, s1, rs, r};
        imm   = im;
        immv  = iv;
        dest  = d;
        ch    = c;
        flush = fl;
        exr   = er;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        logic [4:0]  r_rob;
        logic [5:0]  r_rs1, r_rs2, r_dest;
        logic        r_imm, r_rsvd, r_v, r_fl, exp_rdy, acc;
        logic [0:0]  r_ch;
        logic [31:0] r_iv;
        logic [1:0]  r_er;
        pkt_t        p;

        for (int i = 0; i < 64; i++) prf[i] = 32'h100 + i;
        prf[5] = 32'h11;
        for (int i = 0; i < 32; i++) iram[i] = 7'(i ^ 7'h55);

        //       v rob rs1 im iv     c fl er     rdy ev     a0      b0      r0  a1      b1      r1
        tv[0]  = '{0, 0,  0,  0, 0,     0, 0, 2'b11, 1, 2'b00, 0,      0,      0,  0,      0,      0};
        tv[1]  = '{1, 3,  5,  1, 32'h20, 0, 0, 2'b11, 1, 2'b01, 32'h11, 32'h20, 3,  0,      0,      0};
        tv[2]  = '{1, 4,  5,  1, 32'h20, 1, 0, 2'b11, 1, 2'b10, 0,      0,      0,  32'h11, 32'h107, 4};
        tv[3]  = '{0, 0,  0,  0, 0,     0, 0, 2'b11, 1, 2'b00, 0,      0,      0,  0,      0,      0};
        tv[4]  = '{1, 8,  1,  0, 0,     0, 0, 2'b00, 1, 2'b01, 32'h101, 32'h107, 8, 0,      0,      0};
        tv[5]  = '{1, 9,  2,  0, 0,     0, 0, 2'b00, 1, 2'b01, 32'h101, 32'h107, 8, 0,      0,      0};
        tv[6]  = '{1, 10, 3,  0, 0,     0, 0, 2'b00, 0, 2'b01, 32'h101, 32'h107, 8, 0,      0,      0};
        tv[7]  = '{0, 0,  0,  0, 0,     0, 0, 2'b01, 0, 2'b01, 32'h102, 32'h107, 9, 0,      0,      0};
        tv[8]  = '{0, 0,  0,  0, 0,     0, 0, 2'b01, 1, 2'b00, 0,      0,      0,  0,      0,      0};
        tv[9]  = '{1, 11, 4,  0, 0,     0, 0, 2'b00, 1, 2'b01, 32'h104, 32'h107, 11, 0,     0,      0};
        tv[10] = '{1, 12, 6,  0, 0,     0, 0, 2'b00, 1, 2'b01, 32'h104, 32'h107, 11, 0,     0,      0};
        tv[11] = '{1, 13, 8,  0, 0,     1, 0, 2'b00, 1, 2'b11, 32'h104, 32'h107, 11, 32'h108, 32'h107, 13};
        tv[12] = '{1, 14, 9,  0, 0,     1, 0, 2'b00, 1, 2'b11, 32'h104, 32'h107, 11, 32'h108, 32'h107, 13};
        tv[13] = '{1, 15, 10, 0, 0,     0, 1, 2'b00, 0, 2'b00, 0,      0,      0,  0,      0,      0};
        tv[14] = '{0, 0,  0,  0, 0,     0, 0, 2'b00, 1, 2'b00, 0,      0,      0,  0,      0,      0};

        rst    = 1'b1;
        valid1 = 1'b0;
        ch1    = 2'd0;
        exr1   = 3'b111;
        drive(0, 0, 0, 7, 0, 0, 0, 6'h2A, 0, 0, 2'b11);

        repeat (2) @(negedge clk);
        chk("reset_valid", 128'(ev), 128'(0));
        chk("reset_valid3", 128'(ev1), 128'(0));
        chk("reset_bad", 128'({bad, bad1}), 128'(0));
        chk("reset_data", 128'(ex_a), 128'(0));
        chk("reset_ready", 128'(ready), 128'(1));
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(tv[i].v, tv[i].rob, tv[i].rs1, 6'd7, 1'b0, tv[i].im,
                  tv[i].iv, 6'h2A, tv[i].c, tv[i].fl, tv[i].er);
            #1;
            chk($sformatf("tv%0d_ready", i), 128'(ready), 128'(tv[i].rdy));
            chk($sformatf("tv%0d_addr", i), 128'({rob_o, rs1_o, rs2_o}),
                128'({tv[i].rob, tv[i].rs1, 6'd7}));
            @(posedge clk);
            #1;
            chk($sformatf("tv%0d_valid", i), 128'(ev), 128'(tv[i].ev));
            if (tv[i].ev[0])
                chk($sformatf("tv%0d_ch0", i),
                    128'({ex_a[31:0], ex_b[31:0], ex_rob[4:0]}),
                    128'({tv[i].a0, tv[i].b0, tv[i].r0}));
            if (tv[i].ev[1])
                chk($sformatf("tv%0d_ch1", i),
                    128'({ex_a[63:32], ex_b[63:32], ex_rob[9:5]}),
                    128'({tv[i].a1, tv[i].b1, tv[i].r1}));
        end

        // async reset while channel 0 is stalled with main + skid full
        @(negedge clk);
        drive(1, 20, 1, 7, 0, 0, 0, 6'h2A, 0, 0, 2'b00);
        @(negedge clk);
        drive(1, 21, 2, 7, 0, 0, 0, 6'h2A, 0, 0, 2'b00);
        @(negedge clk);
        valid = 1'b0;
        chk("stall_pre", 128'({ev, ready}), 128'({2'b01, 1'b0}));
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", 128'(ev), 128'(0));
        @(negedge clk);
        rst = 1'b0;
        drive(1, 22, 5, 7, 0, 1, 32'h55, 6'h2A, 0, 0, 2'b11);
        #1;
        chk("arst_ready", 128'(ready), 128'(1));
        @(posedge clk);
        #1;
        chk("arst_first", 128'({ev, ex_a[31:0], ex_b[31:0], ex_rob[4:0]}),
            128'({2'b01, 32'h11, 32'h55, 5'd22}));
        @(negedge clk);
        valid = 1'b0;
        @(posedge clk);
        #1;
        chk("arst_drain", 128'(ev), 128'(0));

        // three-channel instance: out-of-range channel and masked immediate
        @(negedge clk);
        valid1 = 1'b1;
        ch1    = 2'd3;
        #1;
        chk("bad_ready", 128'(ready1), 128'(1));
        @(posedge clk);
        #1;
        chk("bad_pulse", 128'({bad1, ev1}), 128'({1'b1, 3'b000}));
        @(negedge clk);
        valid1 = 1'b0;
        @(posedge clk);
        #1;
        chk("bad_once", 128'(bad1), 128'(0));
        @(negedge clk);
        valid1 = 1'b1;
        flush  = 1'b1;
        @(posedge clk);
        #1;
        chk("bad_flush", 128'({bad1, ev1}), 128'(0));
        @(negedge clk);
        flush = 1'b0;
        ch1   = 2'd2;
        data  = {6'd7, 6'd5, 1'b0, 5'd6};
        imm   = 1'b1;
        immv  = 32'h77;
        @(posedge clk);
        #1;
        chk("ch2_mask", 128'({ev1, ex_a1[95:64], ex_b1[95:64], ex_rob1[14:10]}),
            128'({3'b100, 32'h11, 32'h107, 5'd6}));
        @(negedge clk);
        valid1 = 1'b0;
        imm    = 1'b0;

        // random traffic against the FIFO model, starting from reset
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        mn[0] = 0;
        mn[1] = 0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            r_v    = ($urandom_range(0, 3) != 0);
            r_rob  = 5'($urandom);
            r_rs1  = 6'($urandom);
            r_rs2  = 6'($urandom);
            r_rsvd = 1'($urandom);
            r_imm  = 1'($urandom);
            r_iv   = $urandom;
            r_dest = 6'($urandom);
            r_ch   = 1'($urandom);
            r_fl   = ($urandom_range(0, 15) == 0);
            r_er   = 2'($urandom);
            drive(r_v, r_rob, r_rs1, r_rs2, r_rsvd, r_imm, r_iv, r_dest,
                  r_ch, r_fl, r_er);
            #1;
            exp_rdy = (mn[r_ch] < 2);
            chk("rnd_ready", 128'(ready), 128'(exp_rdy));
            chk("rnd_addr", 128'({rob_o, rs1_o, rs2_o}),
                128'({r_rob, r_rs1, r_rs2}));
            if (r_fl) begin
                mn[0] = 0;
                mn[1] = 0;
            end else begin
                acc = r_v && exp_rdy;
                for (int c = 0; c < 2; c++) begin
                    if (mn[c] > 0 && r_er[c]) begin
                        mq[c][0] = mq[c][1];
                        mn[c]--;
                    end
                end
                if (acc) begin
                    p.a    = prf[r_rs1];
                    p.b    = (r_imm && mask0[r_ch]) ? r_iv : prf[r_rs2];
                    p.opc  = iram[r_rob];
                    p.rob  = r_rob;
                    p.dest = r_dest;
                    mq[r_ch][mn[r_ch]] = p;
                    mn[r_ch]++;
                end
            end
            @(posedge clk);
            #1;
            for (int c = 0; c < 2; c++) begin
                chk($sformatf("rnd_valid%0d", c), 128'(ev[c]),
                    128'(mn[c] > 0));
                if (mn[c] > 0)
                    chk($sformatf("rnd_pkt%0d", c),
                        128'({ex_a[c*XLEN +: XLEN], ex_b[c*XLEN +: XLEN],
                              ex_opc[c*OPC_W +: OPC_W],
                              ex_rob[c*ROB_W +: ROB_W],
                              ex_dest[c*PRF_W +: PRF_W]}),
                        128'(mq[c][0]));
            end
            chk("rnd_bad", 128'(bad), 128'(0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
